// File: rtl/seq_b_minus_2a.sv
// Two-pass sequencer computing Out = B - 2A as (B - A) - A on one shared subtractor.
// Define SEQ_B_MINUS_2A_OVF_EN to build the signed overflow flag (otherwise ovf is tied 0).
module seq_b_minus_2a #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Out,
    output logic             borrow,
    output logic             ovf
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SUB1 = 2'd1;
    localparam logic [1:0] SUB2 = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]       state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] reg_a;
    logic             c1;
    logic [WIDTH:0]   sum;

    // x - y as x + ~y + 1; bit WIDTH is the carry, which is 1 when no borrow occurred
    function automatic logic [WIDTH:0] sub_step(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
        return {1'b0, x} + {1'b0, ~y} + {{WIDTH{1'b0}}, 1'b1};
    endfunction

    assign sum       = sub_step(acc, reg_a);
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            acc    <= '0;
            reg_a  <= '0;
            c1     <= 1'b0;
            Out    <= '0;
            borrow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        reg_a <= A;
                        acc   <= B;
                        state <= SUB1;
                    end
                end
                SUB1: begin
                    acc   <= sum[WIDTH-1:0];
                    c1    <= sum[WIDTH];
                    state <= SUB2;
                end
                SUB2: begin
                    acc    <= sum[WIDTH-1:0];
                    Out    <= sum[WIDTH-1:0];
                    borrow <= ~c1 | ~sum[WIDTH];
                    state  <= DONE;
                end
                default: begin
                    if (out_ready) state <= IDLE;
                end
            endcase
        end
    end

`ifdef SEQ_B_MINUS_2A_OVF_EN
    logic v1;
    logic ovf_q;
    logic step_v;

    // Signed overflow of a subtract: operands differ in sign and the result sign flips from x
    assign step_v = (acc[WIDTH-1] != reg_a[WIDTH-1]) && (sum[WIDTH-1] != acc[WIDTH-1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1    <= 1'b0;
            ovf_q <= 1'b0;
        end else if (state == SUB1) begin
            v1 <= step_v;
        end else if (state == SUB2) begin
            ovf_q <= v1 | step_v;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_seq_b_minus_2a.sv
// Directed and randomized bench for seq_b_minus_2a against an integer-arithmetic reference.
module tb_seq_b_minus_2a;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Out;
    logic             borrow;
    logic             ovf;

    int checks   = 0;
    int failures = 0;

    seq_b_minus_2a #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Out       (Out),
        .borrow    (borrow),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Reference: true integer value of B - 2A, unsigned and signed interpretations
    task automatic model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         output logic [WIDTH-1:0] o, output logic br, output logic ov);
        longint ud;
        longint sd;
        ud = longint'(b) - 2 * longint'(a);
        sd = longint'($signed(b)) - 2 * longint'($signed(a));
        o  = ud[WIDTH-1:0];
        br = (longint'(b) < 2 * longint'(a));
`ifdef SEQ_B_MINUS_2A_OVF_EN
        ov = (sd > 32767) || (sd < -32768);
`else
        ov = 1'b0;
`endif
    endtask

    // One transaction: accept, check latency and result, hold for stall cycles, release
    task automatic txn(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input int stall, input bit junk);
        logic [WIDTH-1:0] eo;
        logic             ebr;
        logic             eov;
        int               cnt;
        model(a, b, eo, ebr, eov);
        @(negedge clk);
        check("in_ready_idle", in_ready, 1'b1);
        A         = a;
        B         = b;
        in_valid  = 1'b1;
        out_ready = (stall == 0);
        @(posedge clk);
        #1;
        if (junk) begin
            A = 16'd7;
            B = 16'd7;
        end else begin
            in_valid = 1'b0;
            A = $urandom;
            B = $urandom;
        end
        cnt = 0;
        while (!out_valid && cnt < 10) begin
            @(negedge clk);
            cnt++;
            if (cnt >= 2) in_valid = 1'b0;
            if (cnt < 3) check("in_ready_busy", in_ready, 1'b0);
        end
        check("latency", cnt, 3);
        check("out", Out, eo);
        check("borrow", borrow, ebr);
        check("ovf", ovf, eov);
        check("in_ready_done", in_ready, 1'b0);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("hold_valid", out_valid, 1'b1);
            check("hold_out", Out, eo);
            check("hold_in_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("release_valid", out_valid, 1'b0);
        check("release_in_ready", in_ready, 1'b1);
        if (junk) begin
            @(negedge clk);
            check("junk_not_taken", in_ready, 1'b1);
            check("junk_no_valid", out_valid, 1'b0);
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A         = '0;
        B         = '0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out", Out, 16'd0);
        check("rst_borrow", borrow, 1'b0);
        check("rst_ovf", ovf, 1'b0);
        rst = 1'b0;

        txn(16'd5, 16'd20, 0, 1'b0);
        txn(16'd10, 16'd5, 0, 1'b0);
        txn(16'h8000, 16'h0000, 0, 1'b0);
        txn(16'd3, 16'd100, 10, 1'b0);
        txn(16'd1, 16'd9, 0, 1'b1);

        // Asynchronous reset landing in SUB2
        @(negedge clk);
        A        = 16'd2;
        B        = 16'd50;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_in_ready", in_ready, 1'b1);
        check("arst_out_valid", out_valid, 1'b0);
        check("arst_out", Out, 16'd0);
        check("arst_borrow", borrow, 1'b0);
        check("arst_ovf", ovf, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("arst_discard", out_valid, 1'b0);
        end
        txn(16'd4, 16'd8, 0, 1'b0);

        // Corner operands
        txn(16'hFFFF, 16'hFFFF, 0, 1'b0);
        txn(16'h4000, 16'h7FFF, 0, 1'b0);
        txn(16'hC000, 16'h8000, 1, 1'b0);
        txn(16'h0000, 16'h0000, 0, 1'b0);

        for (int i = 0; i < 30; i++) begin
            txn(16'($urandom), 16'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

endmodule
